muldiv_hilo_ctrl: RTL and testbench

Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It owns the architectural HI/LO registers and sits beside EX. It raises a stall request while an iterative operation runs, so the pipeline holds the instruction in EX. It exports HI/LO to EX for MFHI/MFLO and to the ID forwarding bus.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 33 +++
 rtl/muldiv_hilo_ctrl_div_iter_core.sv | 61 ++++++
 rtl/muldiv_hilo_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - operation encodings on the op input
//   - FSM state type (2-bit encoding, exported on the debug state port)
//   - width of the ID-stage HI/LO forwarding bus
//   - helper classifying an operation as signed
// -----------------------------------------------------------------------------
package muldiv_hilo_ctrl_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   // {hi_we, lo_we, hi_next[31:0], lo_next[31:0]}
   localparam int HILO_FWD_WD = 66;

   typedef enum logic [1:0] {
      MD_IDLE    = 2'd0,
      MD_MUL_RUN = 2'd1,
      MD_DIV_RUN = 2'd2,
      MD_DONE    = 2'd3
   } md_state_e;

   // MULT and DIV work on magnitudes and need a sign fix-up at the end.
   function automatic logic md_op_signed(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_div_iter_core.sv
// -----------------------------------------------------------------------------
// div_iter_core
// Unsigned restoring divider datapath: one quotient bit per step.
// The parent owns sequencing, sign fix-up and the divide-by-zero result.
//
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   i_load        capture dividend/divisor, clear the partial remainder
//   i_step        perform one restoring step
//   i_dividend    unsigned dividend magnitude
//   i_divisor     unsigned divisor magnitude
//   o_quo_nxt     quotient after the step in progress (valid on the last step)
//   o_rem_nxt     remainder after the step in progress (valid on the last step)
// -----------------------------------------------------------------------------
module div_iter_core #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [DATA_W-1:0] i_dividend,
   input  logic [DATA_W-1:0] i_divisor,
   output logic [DATA_W-1:0] o_quo_nxt,
   output logic [DATA_W-1:0] o_rem_nxt
);

   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvs;

   logic [DATA_W:0]   w_shift;
   logic [DATA_W-1:0] w_trial;
   logic              w_ge;

   // 33-bit partial remainder: remainder shifted left with the next dividend
   // bit (taken from the top of the quotient shift register).
   assign w_shift = {r_rem, r_quo[DATA_W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   // When w_ge holds the difference is below the divisor, so it fits DATA_W bits.
   assign w_trial = w_shift[DATA_W-1:0] - r_dvs;

   assign o_rem_nxt = w_ge ? w_trial : w_shift[DATA_W-1:0];
   assign o_quo_nxt = {r_quo[DATA_W-2:0], w_ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_quo <= '0;
         r_rem <= '0;
         r_dvs <= '0;
      end else if (i_load) begin
         r_quo <= i_dividend;
         r_rem <= '0;
         r_dvs <= i_divisor;
      end else if (i_step) begin
         r_quo <= o_quo_nxt;
         r_rem <= o_rem_nxt;
      end
   end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_ctrl
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO beside EX. Owns the
// architectural HI/LO registers, requests a pipeline stall while an iterative
// operation runs, and forwards HI/LO writes to the ID bypass.
//
// Build option: define FAST_MUL_EN for a single-cycle combinational multiply
// (IDLE -> DONE, HI/LO written at the accept edge). Divide timing is unchanged.
//
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   start             EX holds a valid HI/LO-class instruction (level)
//   op                0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a, src_b      rs / rt operand values
//   flush             abort the in-flight operation (wins over start)
//   stallreq_muldiv   stall request (combinational)
//   busy              state is MUL_RUN or DIV_RUN (registered)
//   done              one-cycle pulse while in DONE (registered)
//   hi_o, lo_o        HI / LO registers
//   hilo_fwd          {hi_we, lo_we, hi_next, lo_next} in the write cycle
//   o_state           current FSM state (debug)
//
// Handshake: start is a level held by EX; the op is accepted in IDLE when
// start=1 and flush=0. For iterative ops stallreq_muldiv stays high from the
// accept cycle until the last run cycle; in DONE start is ignored because the
// same instruction is leaving EX.
// -----------------------------------------------------------------------------
module muldiv_hilo_ctrl
   import muldiv_hilo_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [2:0]             op,
   input  logic [DATA_W-1:0]      src_a,
   input  logic [DATA_W-1:0]      src_b,
   input  logic                   flush,
   output logic                   stallreq_muldiv,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_W-1:0]      hi_o,
   output logic [DATA_W-1:0]      lo_o,
   output logic [HILO_FWD_WD-1:0] hilo_fwd,
   output md_state_e              o_state
);

   md_state_e           r_state;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done;
   logic                r_busy;
   logic                r_signed;
   logic                r_sign_q;
   logic                r_sign_r;
   logic                r_div_zero;
   logic [DATA_W-1:0]   r_src_a;
   logic [2*DATA_W-1:0] r_acc;
   logic [2*DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0]   r_mplier;

   logic                w_is_mul;
   logic                w_is_div;
   logic                w_signed_op;
   logic                w_accept;
   logic                w_last;
   logic                w_running;
   logic [DATA_W-1:0]   w_mag_a;
   logic [DATA_W-1:0]   w_mag_b;
   logic [2*DATA_W-1:0] w_acc_nxt;
   logic [2*DATA_W-1:0] w_mul_res;
   logic [DATA_W-1:0]   w_quo_nxt;
   logic [DATA_W-1:0]   w_rem_nxt;
   logic [DATA_W-1:0]   w_div_lo;
   logic [DATA_W-1:0]   w_div_hi;
   logic                w_hi_we;
   logic                w_lo_we;
   logic [DATA_W-1:0]   w_hi_nxt;
   logic [DATA_W-1:0]   w_lo_nxt;

   assign w_is_mul    = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
   assign w_is_div    = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   assign w_signed_op = md_op_signed(op);
   assign w_accept    = (r_state == MD_IDLE) && start && !flush;
   assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));
   assign w_running   = ((r_state == MD_MUL_RUN) || (r_state == MD_DIV_RUN)) && !flush;

   assign w_mag_a = (w_signed_op && src_a[DATA_W-1]) ? -src_a : src_a;
   assign w_mag_b = (w_signed_op && src_b[DATA_W-1]) ? -src_b : src_b;

   // Shift-add: add the shifted multiplicand when the current multiplier LSB is 1.
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mul_res = (r_signed && r_sign_q) ? -w_acc_nxt : w_acc_nxt;

   div_iter_core #(.DATA_W(DATA_W)) u_div_core (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept && w_is_div),
      .i_step     ((r_state == MD_DIV_RUN) && !flush),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_quo_nxt  (w_quo_nxt),
      .o_rem_nxt  (w_rem_nxt)
   );

   // Divide by zero returns a fixed pattern with no sign fix-up.
   assign w_div_lo = r_div_zero ? '1 :
                     ((r_signed && r_sign_q) ? -w_quo_nxt : w_quo_nxt);
   assign w_div_hi = r_div_zero ? r_src_a :
                     ((r_signed && r_sign_r) ? -w_rem_nxt : w_rem_nxt);

`ifdef FAST_MUL_EN
   logic [2*DATA_W-1:0] w_fast_prod;
   always_comb begin
      w_fast_prod = '0;
      if (op == MD_OP_MULT)
         w_fast_prod = $signed({{DATA_W{src_a[DATA_W-1]}}, src_a}) *
                       $signed({{DATA_W{src_b[DATA_W-1]}}, src_b});
      else
         w_fast_prod = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
   end
`endif

   // HI/LO write enables and data; also drive the ID forwarding bus.
   always_comb begin
      w_hi_we  = 1'b0;
      w_lo_we  = 1'b0;
      w_hi_nxt = '0;
      w_lo_nxt = '0;
      if (w_accept) begin
         if (op == MD_OP_MTHI) begin
            w_hi_we  = 1'b1;
            w_hi_nxt = src_a;
         end else if (op == MD_OP_MTLO) begin
            w_lo_we  = 1'b1;
            w_lo_nxt = src_a;
         end
`ifdef FAST_MUL_EN
         else if (w_is_mul) begin
            w_hi_we  = 1'b1;
            w_lo_we  = 1'b1;
            w_hi_nxt = w_fast_prod[2*DATA_W-1:DATA_W];
            w_lo_nxt = w_fast_prod[DATA_W-1:0];
         end
`endif
      end else if (w_running && w_last) begin
         w_hi_we = 1'b1;
         w_lo_we = 1'b1;
         if (r_state == MD_MUL_RUN) begin
            w_hi_nxt = w_mul_res[2*DATA_W-1:DATA_W];
            w_lo_nxt = w_mul_res[DATA_W-1:0];
         end else begin
            w_hi_nxt = w_div_hi;
            w_lo_nxt = w_div_lo;
         end
      end
   end

   // Combinational outputs are forced low while reset is asserted.
   assign stallreq_muldiv = !rst && ((w_accept && (w_is_mul || w_is_div)) || w_running);
   assign hilo_fwd        = rst ? '0 : {w_hi_we, w_lo_we, w_hi_nxt, w_lo_nxt};
   assign busy            = r_busy;
   assign done            = r_done;
   assign hi_o            = r_hi;
   assign lo_o            = r_lo;
   assign o_state         = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= MD_IDLE;
         r_hi       <= '0;
         r_lo       <= '0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_signed   <= 1'b0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_div_zero <= 1'b0;
         r_src_a    <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_hi_we) r_hi <= w_hi_nxt;
         if (w_lo_we) r_lo <= w_lo_nxt;

         case (r_state)
            MD_IDLE: begin
               if (w_accept && (w_is_mul || w_is_div)) begin
                  r_cnt    <= '0;
                  r_signed <= w_signed_op;
                  r_sign_q <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
                  r_sign_r <= src_a[DATA_W-1];
                  if (w_is_mul) begin
`ifdef FAST_MUL_EN
                     r_state <= MD_DONE;
                     r_done  <= 1'b1;
`else
                     r_state  <= MD_MUL_RUN;
                     r_busy   <= 1'b1;
                     r_acc    <= '0;
                     r_mcand  <= {{DATA_W{1'b0}}, w_mag_a};
                     r_mplier <= w_mag_b;
`endif
                  end else begin
                     r_state    <= MD_DIV_RUN;
                     r_busy     <= 1'b1;
                     r_div_zero <= (src_b == '0);
                     r_src_a    <= src_a;
                  end
               end
            end

            MD_MUL_RUN: begin
               if (flush) begin
                  r_state <= MD_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc    <= w_acc_nxt;
                  r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
                  r_cnt    <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_state <= MD_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end

            MD_DIV_RUN: begin
               if (flush) begin
                  r_state <= MD_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_state <= MD_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end

            MD_DONE: begin
               r_state <= MD_IDLE;
            end

            default: r_state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stallreq_muldiv;
   logic        busy;
   logic        done;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [65:0] hilo_fwd;
   logic [1:0]  state_dbg;

   int n_assert = 0;
   int n_fail   = 0;

   // Architectural HI/LO as the reference model sees them.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

`ifdef FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   muldiv_hilo_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .op              (op),
      .src_a           (src_a),
      .src_b           (src_b),
      .flush           (flush),
      .stallreq_muldiv (stallreq_muldiv),
      .busy            (busy),
      .done            (done),
      .hi_o            (hi_o),
      .lo_o            (lo_o),
      .hilo_fwd        (hilo_fwd),
      .o_state         (state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- model
   // Architectural results from plain arithmetic: {HI, LO}.
   function automatic logic [63:0] ref_result(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      res = '0;
      case (o)
         3'd0: res = sa * sb;
         3'd1: res = ua * ub;
         3'd2: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = {sr[31:0], sq[31:0]};
            end
         end
         3'd3: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               uq  = ua / ub;
               ur  = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
         default: res = {m_hi, m_lo};
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // --------------------------------------------------------------- driver
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // MULT/MULTU/DIV/DIVU: hold start until DONE, measure stall/busy/done.
   task automatic do_arith(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input string tag);
      logic [63:0] exp;
      logic [65:0] fwd;
      int          stalls, busys, dones, cyc, exp_stall, exp_busy;
      bit          got_done;
      exp      = ref_result(o, a, b);
      fwd      = '0;
      stalls   = 0;
      busys    = 0;
      dones    = 0;
      cyc      = 0;
      got_done = 1'b0;
      exp_stall = (FAST && o < 3'd2) ? 1 : 33;
      exp_busy  = (FAST && o < 3'd2) ? 0 : 32;
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      while (!got_done && cyc < 60) begin
         @(negedge clk);
         if (stallreq_muldiv) stalls++;
         if (busy) busys++;
         if (hilo_fwd[65:64] != 2'b00) fwd = hilo_fwd;
         if (done) begin
            dones++;
            got_done = 1'b1;
         end
         cyc++;
         next_cycle();
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 66'(got_done), 66'd1);
      check({tag, "_stall_cycles"}, 66'(stalls), 66'(exp_stall));
      check({tag, "_busy_cycles"}, 66'(busys), 66'(exp_busy));
      check({tag, "_fwd"}, fwd, {2'b11, exp});
      @(negedge clk);
      check({tag, "_hilo"}, {2'b00, hi_o, lo_o}, {2'b00, exp});
      check({tag, "_done_single"}, 66'({done, stallreq_muldiv, state_dbg}), 66'd0);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      next_cycle();
   endtask

   // MTHI/MTLO: one start cycle, never stalls.
   task automatic do_mt(input logic [2:0] o, input logic [31:0] a, input string tag);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = $urandom;
      @(negedge clk);
      check({tag, "_stall"}, 66'(stallreq_muldiv), 66'd0);
      if (o == 3'd4) begin
         check({tag, "_fwd_we"}, 66'(hilo_fwd[65:64]), 66'd2);
         check({tag, "_fwd_hi"}, 66'(hilo_fwd[63:32]), 66'(a));
         m_hi = a;
      end else begin
         check({tag, "_fwd_we"}, 66'(hilo_fwd[65:64]), 66'd1);
         check({tag, "_fwd_lo"}, 66'(hilo_fwd[31:0]), 66'(a));
         m_lo = a;
      end
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check({tag, "_hilo"}, {2'b00, hi_o, lo_o}, {2'b00, m_hi, m_lo});
      check({tag, "_state"}, 66'(state_dbg), 66'd0);
      next_cycle();
   endtask

   // Reserved op: nothing happens.
   task automatic do_reserved(input logic [2:0] o);
      start = 1'b1;
      op    = o;
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
      check("resv_stall_fwd", {65'd0, stallreq_muldiv} | hilo_fwd, 66'd0);
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check("resv_state_hilo", {state_dbg, hi_o, lo_o}, {2'b00, m_hi, m_lo});
      next_cycle();
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;
      int          sel;

      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'd0;
      src_a = '0;
      src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            {2'b00, hi_o, lo_o} | hilo_fwd | 66'({stallreq_muldiv, busy, done, state_dbg}),
            66'd0);
      rst = 1'b0;
      next_cycle();

      // MTHI / MTLO
      do_mt(3'd4, 32'h1234_5678, "mthi");
      do_mt(3'd5, 32'h9ABC_DEF0, "mtlo");

      // flush in IDLE cancels a same-cycle MTHI
      start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF; flush = 1'b1;
      @(negedge clk);
      check("idle_flush_fwd", hilo_fwd, 66'd0);
      next_cycle();
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_flush_hilo", {2'b00, hi_o, lo_o}, {2'b00, m_hi, m_lo});
      next_cycle();

      // directed multiply / divide
      do_arith(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2");
      do_arith(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "multu_ffx2");
      do_arith(3'd2, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
      do_arith(3'd3, 32'd100, 32'd7, "divu_100_7");
      do_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      do_arith(3'd3, 32'h55, 32'd0, "divu_by0");
      do_arith(3'd2, 32'hFFFF_FFF9, 32'd0, "div_by0_neg");
      do_reserved(3'd6);
      do_reserved(3'd7);

      // flush at run cycle 10 of DIV
      start = 1'b1; op = 3'd2; src_a = $urandom; src_b = $urandom_range(1, 1000);
      next_cycle();
      repeat (9) next_cycle();
      flush = 1'b1;
      @(negedge clk);
      check("flush_stall_drop", 66'({stallreq_muldiv, busy}), 66'd1);
      next_cycle();
      flush = 1'b0; start = 1'b0;
      @(negedge clk);
      check("flush_idle", {state_dbg, hi_o, lo_o}, {2'b00, m_hi, m_lo});
      check("flush_busy", 66'({busy, done, stallreq_muldiv}), 66'd0);
      next_cycle();
      do_arith(3'd0, $urandom, $urandom, "mult_after_flush");

      // asynchronous reset at run cycle 20 of DIVU
      start = 1'b1; op = 3'd3; src_a = $urandom; src_b = $urandom_range(1, 50);
      next_cycle();
      repeat (19) next_cycle();
      #2 rst = 1'b1;
      #1;
      check("async_rst_outputs",
            {2'b00, hi_o, lo_o} | hilo_fwd | 66'({stallreq_muldiv, busy, done, state_dbg}),
            66'd0);
      next_cycle();
      @(negedge clk);
      check("rst_start_ignored", 66'({stallreq_muldiv, busy, state_dbg}), 66'd0);
      start = 1'b0;
      rst   = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      next_cycle();
      do_arith(3'd3, 32'd1000, 32'd33, "divu_after_rst");

      // randomized mix against the model
      for (int i = 0; i < 24; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = $urandom;
         r_b  = $urandom;
         sel  = $urandom_range(0, 9);
         if (sel == 0) r_b = 32'd0;
         else if (sel == 1) begin
            r_a = 32'h8000_0000;
            r_b = 32'hFFFF_FFFF;
         end else if (sel < 5) r_b = 32'($urandom_range(1, 15));
         if (r_op < 3'd4)      do_arith(r_op, r_a, r_b, $sformatf("rnd%0d_op%0d", i, r_op));
         else if (r_op < 3'd6) do_mt(r_op, r_a, $sformatf("rnd%0d_mt", i));
         else                  do_reserved(r_op);
         if ($urandom_range(0, 1) == 1) next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
